// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory: controller states, the RV32 NOP fill
// word, and byte-address decoding into a word index plus fault flag.
package imem_pkg;

    typedef enum logic [1:0] {
        StClear,
        StIdle,
        StLoad
    } state_e;

    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

    typedef struct packed {
        logic        fault;
        logic [31:0] idx;
    } addr_dec_t;

    // Faults on a misaligned byte offset or a word number past the end of the array.
    function automatic addr_dec_t decode_addr(input logic [63:0] addr,
                                              input int unsigned ofs_w,
                                              input int unsigned depth);
        addr_dec_t   d;
        logic [63:0] mask;
        logic [63:0] word;
        mask    = (64'd1 << ofs_w) - 64'd1;
        word    = addr >> ofs_w;
        d.fault = ((addr & mask) != 64'd0) || (word >= 64'(depth));
        d.idx   = 32'(word & 64'(depth - 1));
        return d;
    endfunction

endpackage

// File: rtl/imem_fetch_load_if.sv
// Fetch, load and status signals between the instruction memory (slave) and its users
// (master: PC/fetch stage and boot loader).
interface imem_fetch_load_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic                  en;
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_ready;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_fault;
    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_base;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic                  busy;
    logic [IDX_W:0]        load_count;

    modport master (
        output en, fetch_req, fetch_addr, load_start, load_base, load_valid, load_data,
               load_last,
        input  fetch_ready, fetch_valid, fetch_data, fetch_fault, load_ready, busy, load_count
    );

    modport slave (
        input  en, fetch_req, fetch_addr, load_start, load_base, load_valid, load_data,
               load_last,
        output fetch_ready, fetch_valid, fetch_data, fetch_fault, load_ready, busy, load_count
    );

endinterface

// File: rtl/imem_ram.sv
// Single-port word array: synchronous write, registered read. No reset on the storage so it
// maps onto block RAM.
module imem_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/imem_fetch_load.sv
// Instruction memory controller: clears the array after reset, accepts streamed program
// downloads, and serves 1-cycle-latency fetches while idle.
module imem_fetch_load
    import imem_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] RESET_WORD = DATA_WIDTH'(RV32_NOP)
) (
    input logic              clk,
    input logic              rst,
    imem_fetch_load_if.slave bus
);

    localparam int unsigned OFS_W = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W:0]        cnt_q, cnt_d;
    logic                  fetch_valid_q;
    logic                  fault_q;
    logic                  data_ok_q;

    addr_dec_t             fdec;
    addr_dec_t             bdec;
    logic                  fetch_ready;
    logic                  fetch_acc;
    logic                  load_hs;
    logic                  ram_we;
    logic [IDX_W-1:0]      ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  unused_dec;

    assign fdec = decode_addr(64'(bus.fetch_addr), OFS_W, DEPTH);
    assign bdec = decode_addr(64'(bus.load_base), OFS_W, DEPTH);
    assign unused_dec = ^{fdec.idx[31:IDX_W], bdec.fault, bdec.idx[31:IDX_W]};

    // load_start takes priority over a fetch presented in the same cycle.
    assign fetch_ready = bus.en && (state_q == StIdle) && !bus.load_start;
    assign fetch_acc   = bus.fetch_req && fetch_ready;
    assign load_hs     = bus.en && (state_q == StLoad) && bus.load_valid;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ram_we    = 1'b0;
        ram_addr  = fdec.idx[IDX_W-1:0];
        ram_wdata = RESET_WORD;
        unique case (state_q)
            StClear: begin
                ram_addr = ptr_q;
                if (bus.en) begin
                    ram_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (ptr_q == IDX_W'(DEPTH - 1)) begin
                        state_d = StIdle;
                    end
                end
            end
            StIdle: begin
                if (bus.en && bus.load_start) begin
                    state_d = StLoad;
                    ptr_d   = bdec.idx[IDX_W-1:0];
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                ram_addr  = ptr_q;
                ram_wdata = bus.load_data;
                if (load_hs) begin
                    ram_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (cnt_q != (IDX_W + 1)'(DEPTH)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (bus.load_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StClear;
            ptr_q         <= '0;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            data_ok_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_acc;
            if (fetch_acc) begin
                fault_q   <= fdec.fault;
                data_ok_q <= !fdec.fault;
            end
        end
    end

    imem_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (ram_we),
        .re_i   (fetch_acc),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    // The read register is unreset, so a flag masks it to zero after reset or a fault.
    assign bus.fetch_data  = data_ok_q ? ram_rdata : '0;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_fault = fault_q;
    assign bus.fetch_ready = fetch_ready;
    assign bus.load_ready  = bus.en && (state_q == StLoad);
    assign bus.busy        = (state_q != StIdle);
    assign bus.load_count  = cnt_q;

endmodule

// File: tb/tb_imem_fetch_load.sv
// Scoreboard bench for imem_fetch_load at DEPTH=16: stimulus pushes expected fetch responses,
// a negedge monitor pops and compares them whenever fetch_valid is high.
module tb_imem_fetch_load;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
    } resp_t;

    logic  clk = 1'b0;
    logic  rst;
    resp_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    imem_fetch_load_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    imem_fetch_load #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .RESET_WORD(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic fault);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        #1;
        check("fetch_ready", 32'(bus.fetch_ready), 32'd1);
        exp_q.push_back(resp_t'{data: data, fault: fault});
        tick();
        check("fetch_latency", 32'(bus.fetch_valid), 32'd1);
        bus.fetch_req = 1'b0;
    endtask

    task automatic load3(input logic [31:0] base, input logic [31:0] w [3]);
        bus.load_start = 1'b1;
        bus.load_base  = base;
        tick();
        bus.load_start = 1'b0;
        check("load_busy", 32'(bus.busy), 32'd1);
        check("load_ready", 32'(bus.load_ready), 32'd1);
        check("load_count_start", 32'(bus.load_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = w[i];
            bus.load_last  = (i == 2);
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check("load_done_idle", 32'(bus.busy), 32'd0);
        check("load_count", 32'(bus.load_count), 32'd3);
    endtask

    task automatic wait_clear();
        int n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("clear_cycles", 32'(n), 32'(DEPTH));
    endtask

    initial begin
        forever begin
            resp_t e;
            @(negedge clk);
            if (rst === 1'b0 && bus.fetch_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: fetch_valid=1 with no response expected");
                end else begin
                    e = exp_q.pop_front();
                    check("fetch_data", bus.fetch_data, e.data);
                    check("fetch_fault", 32'(bus.fetch_fault), 32'(e.fault));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.en         = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
        check("rst_fetch_data", bus.fetch_data, 32'd0);
        check("rst_load_count", 32'(bus.load_count), 32'd0);
        rst = 1'b0;
        wait_clear();

        // Cleared array returns the NOP at both ends.
        fetch(32'h00, NOP, 1'b0);
        fetch(32'h3C, NOP, 1'b0);

        // Download and back-to-back readback.
        load3(32'h08, '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C});
        fetch(32'h08, 32'h0000_000A, 1'b0);
        fetch(32'h0C, 32'h0000_000B, 1'b0);
        fetch(32'h10, 32'h0000_000C, 1'b0);
        tick();
        check("data_hold", bus.fetch_data, 32'h0000_000C);
        check("valid_drop", 32'(bus.fetch_valid), 32'd0);

        // Misaligned and out-of-range fetches.
        fetch(32'h06, 32'h0, 1'b1);
        fetch(32'h40, 32'h0, 1'b1);
        tick();
        check("fault_hold", 32'(bus.fetch_fault), 32'd1);
        check("fault_data_zero", bus.fetch_data, 32'd0);

        // Session starting at the last index wraps to 0.
        load3(32'h3C, '{32'h0000_0111, 32'h0000_0222, 32'h0000_0333});
        fetch(32'h3C, 32'h0000_0111, 1'b0);
        fetch(32'h00, 32'h0000_0222, 1'b0);
        fetch(32'h04, 32'h0000_0333, 1'b0);
        fetch(32'h08, 32'h0000_000A, 1'b0);

        // load_valid outside LOAD must not write.
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hDEAD_BEEF;
        bus.load_last  = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check("stray_load_idle", 32'(bus.busy), 32'd0);
        check("load_count_hold", 32'(bus.load_count), 32'd3);
        fetch(32'h00, 32'h0000_0222, 1'b0);

        // Disabled block refuses fetch and load_start.
        bus.en         = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.load_start = 1'b1;
        #1;
        check("en0_fetch_ready", 32'(bus.fetch_ready), 32'd0);
        tick();
        check("en0_no_valid", 32'(bus.fetch_valid), 32'd0);
        check("en0_no_load", 32'(bus.busy), 32'd0);
        bus.fetch_req  = 1'b0;
        bus.load_start = 1'b0;
        bus.en         = 1'b1;

        // load_start beats a simultaneous fetch.
        bus.load_start = 1'b1;
        bus.load_base  = 32'h20;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h00;
        #1;
        check("collide_fetch_ready", 32'(bus.fetch_ready), 32'd0);
        tick();
        bus.load_start = 1'b0;
        bus.fetch_req  = 1'b0;
        check("collide_no_valid", 32'(bus.fetch_valid), 32'd0);
        check("collide_in_load", 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h0000_5A5A;
        bus.load_last  = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check("single_word_count", 32'(bus.load_count), 32'd1);
        fetch(32'h20, 32'h0000_5A5A, 1'b0);

        // Reset in the middle of a download.
        bus.load_start = 1'b1;
        bus.load_base  = 32'h28;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h0000_0077;
        tick();
        bus.load_data  = 32'h0000_0088;
        tick();
        bus.load_valid = 1'b0;
        check("midload_count", 32'(bus.load_count), 32'd2);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd1);
        check("midrst_load_ready", 32'(bus.load_ready), 32'd0);
        check("midrst_load_count", 32'(bus.load_count), 32'd0);
        check("midrst_fetch_data", bus.fetch_data, 32'd0);
        check("midrst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
        tick();
        rst = 1'b0;
        wait_clear();
        for (int i = 0; i < int'(DEPTH); i++) begin
            fetch(32'(i * 4), NOP, 1'b0);
        end
        tick();
        tick();
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
